inst_responder: RTL and testbench
=================================

INST_RESPONDER -- requirements
Module: inst_responder

Interface
REQ-001 Parameter DEPTH, default 2, is the maximum number of accepted requests not yet answered by data_ok; legal values are 2 and 4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 req_valid  input  1  fetch-side request present.
REQ-005 req_op  input  1  0 = read, 1 = write (unsupported).
REQ-006 req_addr  input  64  request byte address.
REQ-007 addr_ok  output  1  request slot free; address handshake = req_valid & addr_ok at a rising edge.
REQ-008 data_ok  output  1  one-cycle response strobe.
REQ-009 rdata  output  64  response data, meaningful only while data_ok=1.
REQ-010 resp_err  output  1  response is for a write request; meaningful only while data_ok=1.
REQ-011 mem_ren  output  1  backend read strobe, one cycle per read.
REQ-012 mem_raddr  output  64  backend doubleword address, bits [2:0] always 0.
REQ-013 mem_rvalid  input  1  backend read data valid; earliest one cycle after mem_ren.
REQ-014 mem_rdata  input  64  backend read data.

Function
REQ-015 Queue: DEPTH-entry FIFO of {req_addr, req_op}; wrapping read/write pointers; count 0..DEPTH.
REQ-016 addr_ok = (count < DEPTH), registered-state based only, never dependent on req_valid.
REQ-017 An accept pushes one entry at that edge; when full, addr_ok=0 and no accept occurs, even if a retire happens at the same edge (no bypass).
REQ-018 Simultaneous accept and retire at one edge leaves count unchanged; pointers both advance with wrap.
REQ-019 Back-end FSM states IDLE, REQ, WAIT_R, RESP; at most one backend read in flight.
REQ-020 IDLE: queue empty -> IDLE; head is read -> REQ; head is write -> RESP.
REQ-021 REQ: mem_ren=1, mem_raddr={head_addr[63:3],3'b000} for exactly this cycle; always -> WAIT_R.
REQ-022 WAIT_R: mem_rvalid=1 -> RESP, capturing mem_rdata into rdata, resp_err<=0; otherwise stay.
REQ-023 Write head entering RESP: rdata<=0, resp_err<=1; no backend access.
REQ-024 RESP: data_ok=1 for exactly one cycle; head entry retired at the edge ending RESP.
REQ-025 RESP exit: next entry (after retire) is read -> REQ; is write -> RESP; queue empty -> IDLE.
REQ-026 Responses are delivered strictly in acceptance order; every accepted request produces exactly one data_ok.
REQ-027 No backpressure on data_ok; the requester captures every response it is given.
REQ-028 mem_rvalid outside WAIT_R is ignored.
REQ-029 Minimum latency: read accepted at edge E0 -> mem_ren high E1..E2 -> data_ok high E3..E4 when mem_rvalid is sampled at E3.
REQ-030 rdata and resp_err hold their last value outside RESP.

Reset
REQ-031 rst=0 immediately forces: state IDLE, count 0, pointers 0, addr_ok=0, data_ok=0, mem_ren=0, mem_raddr=0, rdata=0, resp_err=0.
REQ-032 Reset mid-operation discards all queued entries and any in-flight backend read; the backend shares rst, so no stale mem_rvalid follows.
REQ-033 addr_ok=1 from the first cycle after rst deasserts.

Verification
REQ-034 Single read: req_addr=0x8000_0004, backend returns 0x1111_2222_3333_4444 one cycle after mem_ren -> mem_raddr=0x8000_0000, data_ok at E3, rdata=0x1111_2222_3333_4444, resp_err=0.
REQ-035 Back-to-back reads to 0x8000_0000 and 0x8000_0008 on consecutive edges (DEPTH=2) -> addr_ok=0 after the second accept, two data_ok in order with matching data, addr_ok=1 again after the first retire.
REQ-036 Full queue, req_valid held high -> no third accept until a retire; at the retire edge count 2->1, no accept at that same edge.
REQ-037 Write request (req_op=1) queued between two reads -> three data_ok in order, middle one rdata=0 and resp_err=1, no mem_ren for it.
REQ-038 rst pulsed low while in WAIT_R with 2 entries queued -> all outputs 0 immediately; no data_ok ever produced for the discarded entries.
REQ-039 mem_rvalid pulsed while IDLE -> ignored; rdata unchanged, no data_ok.

Source files
------------

// File: rtl/inst_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// inst_responder
//
// Accepts instruction-fetch requests into a small in-order queue and answers
// each one with a single data_ok strobe. Reads go to a backend memory, with at
// most one read in flight. Writes are unsupported and are answered with
// resp_err=1 and rdata=0, without any backend access.
//
// Parameters
//   DEPTH       queue depth (maximum accepted-but-unanswered requests), 2 or 4
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous reset, active low
//   req_valid   request present
//   req_op      0 = read, 1 = write (answered with an error)
//   req_addr    request byte address
//   addr_ok     queue has a free slot; accept = req_valid & addr_ok
//   data_ok     one-cycle response strobe
//   rdata       response data, valid while data_ok=1, held otherwise
//   resp_err    response belongs to a write, valid while data_ok=1
//   mem_ren     backend read strobe, one cycle per read
//   mem_raddr   backend doubleword address (bits [2:0] are zero)
//   mem_rvalid  backend read data valid
//   mem_rdata   backend read data
// ---------------------------------------------------------------------------
module inst_responder #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_op,
   input  logic [63:0] req_addr,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [63:0] rdata,
   output logic        resp_err,
   output logic        mem_ren,
   output logic [63:0] mem_raddr,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata
);

   // DEPTH is a power of two, so the pointers wrap by plain truncation.
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   // Each entry holds the doubleword address and the op bit; the byte offset
   // within the doubleword never reaches the backend, so it is not stored.
   logic [61:0]   entry_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] rptr_nx;
   logic [CW-1:0] count_q, count_d;
   state_e        state_q, state_d;
   logic [63:0]   rdata_q;
   logic          resp_err_q;

   logic          push;
   logic          pop;
   logic          head_op;
   logic [60:0]   head_dw;
   logic          next_op;

   logic          unused_addr_bits;
   assign unused_addr_bits = ^req_addr[2:0];

   // ------------------------------------------------------------------
   // Request queue
   // ------------------------------------------------------------------
   // rst gates addr_ok so that it reads 0 for the whole time reset is held.
   assign addr_ok = rst && (count_q < CW'(DEPTH));
   assign push    = req_valid && addr_ok;
   // The head is retired on the edge that ends the RESP cycle.
   assign pop     = (state_q == S_RESP);

   assign rptr_nx = rptr_q + PW'(1);
   assign head_op = entry_q[rptr_q][0];
   assign head_dw = entry_q[rptr_q][61:1];

   // Op of the entry that becomes head once the current head retires: the
   // second queued entry if there is one, otherwise a request accepted at
   // that very edge.
   always_comb begin
      next_op = req_op;
      if (count_q > CW'(1)) begin
         next_op = entry_q[rptr_nx][0];
      end
   end

   always_comb begin
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_nx         : rptr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (push) begin
            entry_q[wptr_q] <= {req_addr[63:3], req_op};
         end
      end
   end

   // ------------------------------------------------------------------
   // Backend FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Backend FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            // A request accepted this edge is seen next cycle (no bypass).
            if (count_q != '0) begin
               state_d = head_op ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            state_d = S_WAIT_R;
         end
         S_WAIT_R: begin
            if (mem_rvalid) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if ((count_q > CW'(1)) || push) begin
               state_d = next_op ? S_RESP : S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Backend FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      data_ok   = 1'b0;
      mem_ren   = 1'b0;
      mem_raddr = '0;
      case (state_q)
         S_REQ: begin
            mem_ren   = 1'b1;
            mem_raddr = {head_dw, 3'b000};
         end
         S_RESP: begin
            data_ok = 1'b1;
         end
         default: begin
            data_ok   = 1'b0;
            mem_ren   = 1'b0;
            mem_raddr = '0;
         end
      endcase
   end

   // Response payload. Entering RESP from anywhere but WAIT_R means the head
   // is a write; mem_rvalid outside WAIT_R is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q    <= '0;
         resp_err_q <= 1'b0;
      end else if (state_q == S_WAIT_R) begin
         if (mem_rvalid) begin
            rdata_q    <= mem_rdata;
            resp_err_q <= 1'b0;
         end
      end else if (state_d == S_RESP) begin
         rdata_q    <= '0;
         resp_err_q <= 1'b1;
      end
   end

   assign rdata    = rdata_q;
   assign resp_err = resp_err_q;

endmodule

// File: tb/tb_inst_responder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_inst_responder
//
// Drives fetch requests, models the backend memory and compares every
// response against a scoreboard of expected {rdata, resp_err} values.
// ---------------------------------------------------------------------------
module tb_inst_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_op = 1'b0;
   logic [63:0] req_addr = '0;
   logic        addr_ok;
   logic        data_ok;
   logic [63:0] rdata;
   logic        resp_err;
   logic        mem_ren;
   logic [63:0] mem_raddr;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;

   always #5 clk = ~clk;

   inst_responder #(.DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .addr_ok    (addr_ok),
      .data_ok    (data_ok),
      .rdata      (rdata),
      .resp_err   (resp_err),
      .mem_ren    (mem_ren),
      .mem_raddr  (mem_raddr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        op;
      logic [63:0] addr;
      int          gap;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Backend memory contents as a function of the doubleword address.
   function automatic logic [63:0] mem_fn(input logic [63:0] a);
      if (a == 64'h0000_0000_8000_0000) return 64'h1111_2222_3333_4444;
      return {a[31:0] ^ 32'hCAFE_F00D, a[31:0]};
   endfunction

   function automatic vec_t mk(input logic op, input logic [63:0] addr, input int gap);
      vec_t v;
      v.op        = op;
      v.addr      = addr;
      v.gap       = gap;
      v.exp_rdata = op ? 64'h0 : mem_fn({addr[63:3], 3'b000});
      v.exp_err   = op;
      return v;
   endfunction

   task automatic push_exp(input logic [63:0] rd, input logic err);
      exp_t e;
      e.rdata = rd;
      e.err   = err;
      sb.push_back(e);
   endtask

   // ------------------------------------------------------------------
   // Backend model: answers each mem_ren after bk_cnt extra cycles.
   // ------------------------------------------------------------------
   logic        bk_pend = 1'b0;
   int          bk_cnt = 0;
   logic [63:0] bk_data = '0;
   bit          bk_en = 1'b1;
   bit          bk_rand = 1'b0;
   bit          inject = 1'b0;
   int          ren_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (!rst) begin
            bk_pend = 1'b0;
         end else begin
            if (inject) begin
               mem_rvalid = 1'b1;
               mem_rdata  = 64'hDEAD_0000_BEEF_0000;
               inject     = 1'b0;
            end else if (bk_pend && bk_en) begin
               if (bk_cnt == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = bk_data;
                  bk_pend    = 1'b0;
               end else begin
                  bk_cnt--;
               end
            end
            if (mem_ren) begin
               check("one_in_flight", {63'd0, bk_pend}, 64'd0);
               ren_cnt++;
               bk_pend = 1'b1;
               bk_cnt  = bk_rand ? int'($urandom_range(0, 3)) : 0;
               bk_data = mem_fn(mem_raddr);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response monitor: one line per response.
   // ------------------------------------------------------------------
   int resp_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (data_ok) begin
            exp_t e;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_data_ok: got data_ok=1 with rdata=%h, required no response", rdata);
            end else begin
               e = sb.pop_front();
               check("rdata", rdata, e.rdata);
               check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
            end
            $display("resp %0d: rdata=%h resp_err=%0d", resp_cnt, rdata, resp_err);
            resp_cnt++;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic op, input logic [63:0] addr,
                       input logic [63:0] exp_rd, input logic exp_err);
      int t;
      t = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      while (!addr_ok && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", {63'd0, addr_ok}, 64'd1);
      if (addr_ok) push_exp(exp_rd, exp_err);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      vec_t        tbl[12];
      int          r0;
      int          ren0;
      logic [63:0] saved;
      int          t;

      tbl[0]  = mk(1'b0, 64'h0000_0000_1000_0000, 0);
      tbl[1]  = mk(1'b0, 64'h0000_0000_1000_0008, 0);
      tbl[2]  = mk(1'b1, 64'h0000_0000_1000_0010, 1);
      tbl[3]  = mk(1'b0, 64'h0000_0001_2345_6787, 0);
      tbl[4]  = mk(1'b1, 64'h0000_0000_2000_0000, 0);
      tbl[5]  = mk(1'b1, 64'h0000_0000_2000_0004, 2);
      tbl[6]  = mk(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
      tbl[7]  = mk(1'b0, 64'h0000_0000_0000_0003, 1);
      tbl[8]  = mk(1'b1, 64'h0000_0000_3000_0000, 0);
      tbl[9]  = mk(1'b0, 64'h0000_0000_8000_0006, 0);
      tbl[10] = mk(1'b0, 64'h0000_0000_4000_0020, 2);
      tbl[11] = mk(1'b0, 64'h0000_0000_4000_002C, 0);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_addr_ok",  {63'd0, addr_ok},  64'd0);
      check("rst_data_ok",  {63'd0, data_ok},  64'd0);
      check("rst_mem_ren",  {63'd0, mem_ren},  64'd0);
      check("rst_mem_raddr", mem_raddr, 64'd0);
      check("rst_rdata",     rdata,     64'd0);
      check("rst_resp_err", {63'd0, resp_err}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("addr_ok_after_reset", {63'd0, addr_ok}, 64'd1);

      // Single read, minimum latency
      send(1'b0, 64'h0000_0000_8000_0004, 64'h1111_2222_3333_4444, 1'b0);
      check("lat_e0_mem_ren", {63'd0, mem_ren}, 64'd0);
      check("lat_e0_addr_ok", {63'd0, addr_ok}, 64'd1);
      @(negedge clk);
      check("lat_e1_mem_ren", {63'd0, mem_ren}, 64'd1);
      check("lat_e1_mem_raddr", mem_raddr, 64'h0000_0000_8000_0000);
      @(negedge clk);
      check("lat_e2_mem_ren", {63'd0, mem_ren}, 64'd0);
      check("lat_e2_data_ok", {63'd0, data_ok}, 64'd0);
      @(negedge clk);
      check("lat_e3_data_ok", {63'd0, data_ok}, 64'd1);
      @(negedge clk);
      check("lat_e4_data_ok", {63'd0, data_ok}, 64'd0);
      check("rdata_hold", rdata, 64'h1111_2222_3333_4444);

      // Back-to-back reads, full queue with req_valid held
      check("b2b_first_ok", {63'd0, addr_ok}, 64'd1);
      push_exp(mem_fn(64'h0000_0000_8000_0000), 1'b0);
      req_valid = 1'b1;
      req_op    = 1'b0;
      req_addr  = 64'h0000_0000_8000_0000;
      @(negedge clk);
      check("b2b_after_first", {63'd0, addr_ok}, 64'd1);
      push_exp(mem_fn(64'h0000_0000_8000_0008), 1'b0);
      req_addr = 64'h0000_0000_8000_0008;
      @(negedge clk);
      check("full_after_second", {63'd0, addr_ok}, 64'd0);
      req_addr = 64'h0000_0000_8000_0010;
      t = 0;
      while (!data_ok && t < 20) begin
         @(negedge clk);
         t++;
         if (!data_ok) check("full_hold", {63'd0, addr_ok}, 64'd0);
      end
      check("first_resp_seen", {63'd0, data_ok}, 64'd1);
      check("no_accept_at_retire", {63'd0, addr_ok}, 64'd0);
      @(negedge clk);
      check("addr_ok_after_retire", {63'd0, addr_ok}, 64'd1);
      push_exp(mem_fn(64'h0000_0000_8000_0010), 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      drain();

      // Write between two reads
      ren0 = ren_cnt;
      send(1'b0, 64'h0000_0000_8000_0100, mem_fn(64'h0000_0000_8000_0100), 1'b0);
      send(1'b1, 64'h0000_0000_8000_0208, 64'h0, 1'b1);
      send(1'b0, 64'h0000_0000_8000_0310, mem_fn(64'h0000_0000_8000_0310), 1'b0);
      drain();
      check("write_no_mem_ren", 64'(ren_cnt - ren0), 64'd2);

      // mem_rvalid while idle
      repeat (2) @(negedge clk);
      saved  = rdata;
      r0     = resp_cnt;
      inject = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_rvalid_rdata", rdata, saved);
      check("idle_rvalid_no_resp", 64'(resp_cnt - r0), 64'd0);

      // Table-driven stream with random backend latency
      bk_rand = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send(tbl[i].op, tbl[i].addr, tbl[i].exp_rdata, tbl[i].exp_err);
         repeat (tbl[i].gap) @(negedge clk);
      end
      drain();
      bk_rand = 1'b0;

      // Reset while waiting on the backend with two entries queued
      bk_en = 1'b0;
      send(1'b0, 64'h0000_0000_8000_0400, mem_fn(64'h0000_0000_8000_0400), 1'b0);
      send(1'b0, 64'h0000_0000_8000_0408, mem_fn(64'h0000_0000_8000_0408), 1'b0);
      repeat (2) @(negedge clk);
      check("wait_r_no_resp", {63'd0, data_ok}, 64'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_addr_ok",  {63'd0, addr_ok},  64'd0);
      check("mid_rst_data_ok",  {63'd0, data_ok},  64'd0);
      check("mid_rst_mem_ren",  {63'd0, mem_ren},  64'd0);
      check("mid_rst_mem_raddr", mem_raddr, 64'd0);
      check("mid_rst_rdata",     rdata,     64'd0);
      check("mid_rst_resp_err", {63'd0, resp_err}, 64'd0);
      sb.delete();
      r0 = resp_cnt;
      repeat (2) @(negedge clk);
      rst   = 1'b1;
      bk_en = 1'b1;
      repeat (10) @(negedge clk);
      check("no_resp_after_rst", 64'(resp_cnt - r0), 64'd0);
      check("addr_ok_after_mid_rst", {63'd0, addr_ok}, 64'd1);

      // Recovery after reset
      send(1'b0, 64'h0000_0000_8000_0000, 64'h1111_2222_3333_4444, 1'b0);
      send(1'b1, 64'h0000_0000_9000_0000, 64'h0, 1'b1);
      drain();
      check("recovery_resp_count", 64'(resp_cnt - r0), 64'd2);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
